lnrv_ifu_prefetch: RTL and testbench
====================================

LNRV_IFU_PREFETCH -- requirements
Module: lnrv_ifu_prefetch

Interface
REQ-001 SHALL have parameter P_OTS_MAX, default 2, giving the maximum outstanding bus fetches (legal 1..4).
REQ-002 SHALL have parameter P_BUF_DEPTH, default 4, giving the prefetch buffer entries (power of 2, 2..8, and >= P_OTS_MAX).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- reset_vector  in  32  first fetch address
- pipe_flush_req  in  1  redirect request
- pipe_flush_ack  out  1  redirect accepted, tied 1
- pipe_flush_pc_op1, pipe_flush_pc_op2  in  32 each  redirect target = op1+op2
- pipe_halt_req  in  1  stop fetching
- pipe_halt_ack  out  1  halted, no outstanding fetch
- ifu_cmd_vld  out  1  bus read request valid
- ifu_cmd_rdy  in  1  bus read request ready
- ifu_cmd_addr  out  32  bus read address
- ifu_cmd_write  out  1  tied 0
- ifu_cmd_wdata  out  32  tied 0
- ifu_cmd_wstrb  out  4  tied 0
- ifu_cmd_size  out  3  tied 2
- ifu_rsp_vld  in  1  bus response valid
- ifu_rsp_rdy  out  1  bus response ready, tied 1
- ifu_rsp_rdata  in  32  bus response data
- ifu_rsp_err  in  1  bus response error
- ifu_ir_vld  out  1  instruction valid to EXU
- ifu_ir_rdy  in  1  EXU accepts instruction
- ifu_pc, ifu_ir  out  32 each  instruction address and word
- ifu_buserr, ifu_misalgn  out  1 each  entry error flags

Function
REQ-005 SHALL hold fetch_pc (32b); ifu_cmd_addr = fetch_pc; each cmd handshake does fetch_pc += 4, wrapping mod 2^32.
REQ-006 SHALL track ots_cnt (outstanding cmds) and buf_cnt (buffered entries).
REQ-007 ifu_cmd_vld SHALL = ~pipe_flush_req & ~pipe_halt_req & ~misalgn_lock & (ots_cnt < P_OTS_MAX) & (ots_cnt + buf_cnt < P_BUF_DEPTH).
REQ-008 SHALL push the address of every handshaken cmd into an internal PC FIFO of depth P_OTS_MAX; responses are in order.
REQ-009 A response with drop_cnt == 0 SHALL write {rsp_err, rdata, popped PC, misalgn=0} into the buffer; the entry becomes visible on ifu_ir_vld the next cycle (no bypass).
REQ-010 ifu_ir_vld SHALL = (buf_cnt != 0) & ~pipe_flush_req; ifu_ir_vld & ifu_ir_rdy pops the head entry.
REQ-011 A simultaneous buffer push and pop SHALL leave buf_cnt unchanged.
REQ-012 On pipe_flush_req:
- the buffer is cleared at the clock edge;
- fetch_pc <= op1+op2 (32b wrap);
- drop_cnt <= ots_cnt after this cycle's response;
- reset_pend clears.
REQ-013 While drop_cnt > 0, each response SHALL be consumed without buffering, decrementing drop_cnt and ots_cnt and popping the PC FIFO.
REQ-014 Flush redirect target with bits [1:0] != 0:
- no cmd is issued;
- one buffer entry {ir=0, pc=target, misalgn=1, buserr=0} is written, visible the cycle after the flush;
- misalgn_lock sets and holds until the next flush.
REQ-015 A flush arriving while drop_cnt > 0 SHALL reload drop_cnt with all still-outstanding cmds.
REQ-016 pipe_halt_ack SHALL be registered:
- sets the cycle after pipe_halt_req is high with ots_cnt == 0;
- clears the cycle after pipe_halt_req falls;
- buffered entries remain poppable while halted.
REQ-017 With reset_pend set, fetch_pc SHALL track reset_vector; the first cmd handshake clears reset_pend.

Reset
REQ-018 While reset is high:
- ots_cnt = buf_cnt = drop_cnt = 0;
- misalgn_lock = 0, pipe_halt_ack = 0, reset_pend = 1;
- ifu_ir_vld = 0;
- ifu_cmd_vld = 1 unless halt is requested.
REQ-019 Reset asserted mid-operation SHALL discard all outstanding and buffered state; responses arriving after reset release are undefined bench stimulus.

Verification
REQ-020 Reset, reset_vector=0x8000_0000, cmd_rdy=1, rsp 1-cycle latency, ir_rdy=0 -> exactly 4 cmds (0x8000_0000..0x8000_000C), then ifu_cmd_vld=0 with buf_cnt=4.
REQ-021 Two cmds outstanding, flush to 0x100+0x20 -> both responses dropped, next cmd addr 0x120, first ifu_pc=0x120.
REQ-022 Flush to 0x0+0x102 -> no cmd issued, ifu_ir_vld=1 with ifu_misalgn=1 and ifu_pc=0x102, no further cmds until the next flush.
REQ-023 ifu_rsp_err=1 on the fetch at 0x8000_0004 -> entry ifu_buserr=1, ifu_pc=0x8000_0004; neighbouring entries have buserr=0.
REQ-024 pipe_halt_req with 2 outstanding -> pipe_halt_ack rises the cycle after the 2nd response; ifu_cmd_vld=0 throughout the halt.
REQ-025 fetch_pc=0xFFFF_FFFC handshake -> next ifu_cmd_addr=0x0000_0000.

Source files
------------

// File: rtl/lnrv_ifu_prefetch.sv
// lnrv_ifu_prefetch: instruction prefetch unit.
// Issues in-order 32-bit bus reads from a running fetch PC, parks returned words
// in a small prefetch buffer and presents them to the execution unit. A pipeline
// flush redirects fetching, discards buffered words and drops responses to
// reads already in flight. A misaligned redirect target produces a single
// error entry and stops fetching until the next redirect.
module lnrv_ifu_prefetch #(
    parameter int P_OTS_MAX   = 2,
    parameter int P_BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reset_vector,
    input  logic        pipe_flush_req,
    output logic        pipe_flush_ack,
    input  logic [31:0] pipe_flush_pc_op1,
    input  logic [31:0] pipe_flush_pc_op2,
    input  logic        pipe_halt_req,
    output logic        pipe_halt_ack,
    output logic        ifu_cmd_vld,
    input  logic        ifu_cmd_rdy,
    output logic [31:0] ifu_cmd_addr,
    output logic        ifu_cmd_write,
    output logic [31:0] ifu_cmd_wdata,
    output logic [3:0]  ifu_cmd_wstrb,
    output logic [2:0]  ifu_cmd_size,
    input  logic        ifu_rsp_vld,
    output logic        ifu_rsp_rdy,
    input  logic [31:0] ifu_rsp_rdata,
    input  logic        ifu_rsp_err,
    output logic        ifu_ir_vld,
    input  logic        ifu_ir_rdy,
    output logic [31:0] ifu_pc,
    output logic [31:0] ifu_ir,
    output logic        ifu_buserr,
    output logic        ifu_misalgn
);

    localparam int         BUF_AW      = $clog2(P_BUF_DEPTH);
    localparam logic [3:0] OTS_MAX_C   = 4'(P_OTS_MAX);
    localparam logic [4:0] BUF_DEPTH_C = 5'(P_BUF_DEPTH);
    localparam logic [1:0] PCF_LAST_C  = 2'(P_OTS_MAX - 1);

    // Control state
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              reset_pend_q, reset_pend_d;
    logic [3:0]        ots_cnt_q, ots_cnt_d;
    logic [3:0]        buf_cnt_q, buf_cnt_d;
    logic [3:0]        drop_cnt_q, drop_cnt_d;
    logic              misalgn_lock_q, misalgn_lock_d;
    logic              halt_ack_q, halt_ack_d;
    logic [1:0]        pcf_wr_q, pcf_wr_d;
    logic [1:0]        pcf_rd_q, pcf_rd_d;
    logic [BUF_AW-1:0] buf_wr_q, buf_wr_d;
    logic [BUF_AW-1:0] buf_rd_q, buf_rd_d;

    // Storage: PC of each in-flight read, and the prefetch buffer entries
    logic [31:0]       pcf_mem_q [0:3];
    logic [31:0]       buf_ir_q  [0:P_BUF_DEPTH-1];
    logic [31:0]       buf_pc_q  [0:P_BUF_DEPTH-1];
    logic              buf_err_q [0:P_BUF_DEPTH-1];
    logic              buf_mis_q [0:P_BUF_DEPTH-1];

    // Datapath helpers
    logic [31:0]       cur_pc;
    logic [31:0]       flush_tgt;
    logic              flush_mis;
    logic              cmd_hs;
    logic              rsp_drop;
    logic              rsp_push;
    logic              ir_pop;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_wa;
    logic [31:0]       buf_w_ir;
    logic [31:0]       buf_w_pc;
    logic              buf_w_err;
    logic              buf_w_mis;

    // The PC FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [1:0] pcf_inc(input logic [1:0] p);
        return (p == PCF_LAST_C) ? 2'd0 : p + 2'd1;
    endfunction

    // Until the first read goes out, the fetch address follows the reset vector.
    assign cur_pc    = reset_pend_q ? reset_vector : fetch_pc_q;
    assign flush_tgt = pipe_flush_pc_op1 + pipe_flush_pc_op2;
    assign flush_mis = |flush_tgt[1:0];

    assign ifu_cmd_vld = ~pipe_flush_req & ~pipe_halt_req & ~misalgn_lock_q
                       & (ots_cnt_q < OTS_MAX_C)
                       & (({1'b0, ots_cnt_q} + {1'b0, buf_cnt_q}) < BUF_DEPTH_C);
    assign ifu_cmd_addr  = cur_pc;
    assign ifu_cmd_write = 1'b0;
    assign ifu_cmd_wdata = 32'd0;
    assign ifu_cmd_wstrb = 4'd0;
    assign ifu_cmd_size  = 3'd2;
    assign ifu_rsp_rdy   = 1'b1;

    assign pipe_flush_ack = 1'b1;
    assign pipe_halt_ack  = halt_ack_q;

    assign cmd_hs   = ifu_cmd_vld & ifu_cmd_rdy;
    assign rsp_drop = ifu_rsp_vld & (drop_cnt_q != 4'd0);
    assign rsp_push = ifu_rsp_vld & (drop_cnt_q == 4'd0);

    assign ifu_ir_vld  = (buf_cnt_q != 4'd0) & ~pipe_flush_req;
    assign ir_pop      = ifu_ir_vld & ifu_ir_rdy;
    assign ifu_pc      = buf_pc_q[buf_rd_q];
    assign ifu_ir      = buf_ir_q[buf_rd_q];
    assign ifu_buserr  = buf_err_q[buf_rd_q];
    assign ifu_misalgn = buf_mis_q[buf_rd_q];

    // Next-state: fetch PC, in-flight/buffer bookkeeping, redirect handling.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        reset_pend_d   = reset_pend_q;
        ots_cnt_d      = ots_cnt_q + {3'b0, cmd_hs} - {3'b0, ifu_rsp_vld};
        buf_cnt_d      = buf_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        misalgn_lock_d = misalgn_lock_q;
        pcf_wr_d       = pcf_wr_q;
        pcf_rd_d       = pcf_rd_q;
        buf_wr_d       = buf_wr_q;
        buf_rd_d       = buf_rd_q;
        buf_we         = 1'b0;
        buf_wa         = buf_wr_q;
        buf_w_ir       = ifu_rsp_rdata;
        buf_w_pc       = pcf_mem_q[pcf_rd_q];
        buf_w_err      = ifu_rsp_err;
        buf_w_mis      = 1'b0;

        if (cmd_hs) begin
            fetch_pc_d   = cur_pc + 32'd4;
            reset_pend_d = 1'b0;
            pcf_wr_d     = pcf_inc(pcf_wr_q);
        end
        if (ifu_rsp_vld) begin
            pcf_rd_d = pcf_inc(pcf_rd_q);
        end
        if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - 4'd1;
        end

        if (pipe_flush_req) begin
            // Every read still in flight after this cycle belongs to the old stream.
            fetch_pc_d     = flush_tgt;
            reset_pend_d   = 1'b0;
            drop_cnt_d     = ots_cnt_q - {3'b0, ifu_rsp_vld};
            misalgn_lock_d = flush_mis;
            buf_rd_d       = '0;
            if (flush_mis) begin
                buf_we    = 1'b1;
                buf_wa    = '0;
                buf_w_ir  = 32'd0;
                buf_w_pc  = flush_tgt;
                buf_w_err = 1'b0;
                buf_w_mis = 1'b1;
                buf_wr_d  = BUF_AW'(1);
                buf_cnt_d = 4'd1;
            end else begin
                buf_wr_d  = '0;
                buf_cnt_d = 4'd0;
            end
        end else begin
            if (rsp_push) begin
                buf_we   = 1'b1;
                buf_wr_d = buf_wr_q + BUF_AW'(1);
            end
            if (ir_pop) begin
                buf_rd_d = buf_rd_q + BUF_AW'(1);
            end
            buf_cnt_d = buf_cnt_q + {3'b0, rsp_push} - {3'b0, ir_pop};
        end

        halt_ack_d = pipe_halt_req & (ots_cnt_d == 4'd0);
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q     <= 32'd0;
            reset_pend_q   <= 1'b1;
            ots_cnt_q      <= 4'd0;
            buf_cnt_q      <= 4'd0;
            drop_cnt_q     <= 4'd0;
            misalgn_lock_q <= 1'b0;
            halt_ack_q     <= 1'b0;
            pcf_wr_q       <= 2'd0;
            pcf_rd_q       <= 2'd0;
            buf_wr_q       <= '0;
            buf_rd_q       <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            reset_pend_q   <= reset_pend_d;
            ots_cnt_q      <= ots_cnt_d;
            buf_cnt_q      <= buf_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            misalgn_lock_q <= misalgn_lock_d;
            halt_ack_q     <= halt_ack_d;
            pcf_wr_q       <= pcf_wr_d;
            pcf_rd_q       <= pcf_rd_d;
            buf_wr_q       <= buf_wr_d;
            buf_rd_q       <= buf_rd_d;
        end
    end

    // Storage writes; contents are only meaningful where the counters say so.
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            pcf_mem_q[pcf_wr_q] <= cur_pc;
        end
        if (buf_we) begin
            buf_ir_q[buf_wa]  <= buf_w_ir;
            buf_pc_q[buf_wa]  <= buf_w_pc;
            buf_err_q[buf_wa] <= buf_w_err;
            buf_mis_q[buf_wa] <= buf_w_mis;
        end
    end

endmodule

// File: tb/tb_lnrv_ifu_prefetch.sv
// Testbench for lnrv_ifu_prefetch: queue-based reference model of the fetch
// stream, randomized bus/EXU/flush/halt stimulus, and directed scenarios.
module tb_lnrv_ifu_prefetch;

    localparam int OTS_MAX   = 2;
    localparam int BUF_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] reset_vector;
    logic        pipe_flush_req;
    logic        pipe_flush_ack;
    logic [31:0] pipe_flush_pc_op1;
    logic [31:0] pipe_flush_pc_op2;
    logic        pipe_halt_req;
    logic        pipe_halt_ack;
    logic        ifu_cmd_vld;
    logic        ifu_cmd_rdy;
    logic [31:0] ifu_cmd_addr;
    logic        ifu_cmd_write;
    logic [31:0] ifu_cmd_wdata;
    logic [3:0]  ifu_cmd_wstrb;
    logic [2:0]  ifu_cmd_size;
    logic        ifu_rsp_vld;
    logic        ifu_rsp_rdy;
    logic [31:0] ifu_rsp_rdata;
    logic        ifu_rsp_err;
    logic        ifu_ir_vld;
    logic        ifu_ir_rdy;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_ir;
    logic        ifu_buserr;
    logic        ifu_misalgn;

    lnrv_ifu_prefetch #(
        .P_OTS_MAX   (OTS_MAX),
        .P_BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .reset_vector      (reset_vector),
        .pipe_flush_req    (pipe_flush_req),
        .pipe_flush_ack    (pipe_flush_ack),
        .pipe_flush_pc_op1 (pipe_flush_pc_op1),
        .pipe_flush_pc_op2 (pipe_flush_pc_op2),
        .pipe_halt_req     (pipe_halt_req),
        .pipe_halt_ack     (pipe_halt_ack),
        .ifu_cmd_vld       (ifu_cmd_vld),
        .ifu_cmd_rdy       (ifu_cmd_rdy),
        .ifu_cmd_addr      (ifu_cmd_addr),
        .ifu_cmd_write     (ifu_cmd_write),
        .ifu_cmd_wdata     (ifu_cmd_wdata),
        .ifu_cmd_wstrb     (ifu_cmd_wstrb),
        .ifu_cmd_size      (ifu_cmd_size),
        .ifu_rsp_vld       (ifu_rsp_vld),
        .ifu_rsp_rdy       (ifu_rsp_rdy),
        .ifu_rsp_rdata     (ifu_rsp_rdata),
        .ifu_rsp_err       (ifu_rsp_err),
        .ifu_ir_vld        (ifu_ir_vld),
        .ifu_ir_rdy        (ifu_ir_rdy),
        .ifu_pc            (ifu_pc),
        .ifu_ir            (ifu_ir),
        .ifu_buserr        (ifu_buserr),
        .ifu_misalgn       (ifu_misalgn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the fetch stream as queues of reads in flight and buffered words.
    typedef struct {
        logic [31:0] pc;
        logic        drop;
    } ots_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        err;
        logic        mis;
    } ent_t;

    ots_t        m_ots[$];
    ent_t        m_buf[$];
    logic        m_pend;
    logic [31:0] m_pc;
    logic        m_lock;
    logic        m_hack;

    // Bus responder: addresses the DUT has actually issued, answered in order.
    logic [31:0] rsp_q[$];
    logic [31:0] cmd_log[$];

    // Stimulus knobs
    int unsigned cmd_rdy_pct, ir_rdy_pct, rsp_pct, flush_pct, halt_pct, err_pct;
    logic        halt_mode, halt_val;
    logic        drive_reset;
    logic        force_flush;
    logic [31:0] f_op1, f_op2;
    logic [31:0] err_addr;

    int n_chk;
    int n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = 1'b1;
        m_pc   = 32'd0;
        m_ots.delete();
        m_buf.delete();
        m_lock = 1'b0;
        m_hack = 1'b0;
    endtask

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock cycle: drive after the edge, check and advance the model at the falling edge.
    task automatic tick();
        logic [31:0] exp_addr, tgt;
        logic        exp_cmd, exp_ir, hs;
        ots_t        o;
        ent_t        e;
        @(posedge clk);
        #1;
        reset = drive_reset;
        if (drive_reset) begin
            model_reset();
            rsp_q.delete();
        end
        if (force_flush) begin
            pipe_flush_req    = 1'b1;
            pipe_flush_pc_op1 = f_op1;
            pipe_flush_pc_op2 = f_op2;
            force_flush       = 1'b0;
        end else if (!drive_reset && ($urandom_range(99) < flush_pct)) begin
            pipe_flush_req    = 1'b1;
            pipe_flush_pc_op1 = $urandom;
            pipe_flush_pc_op2 = $urandom;
            if ($urandom_range(3) != 0)
                pipe_flush_pc_op2 = pipe_flush_pc_op2 - ((pipe_flush_pc_op1 + pipe_flush_pc_op2) & 32'd3);
        end else begin
            pipe_flush_req    = 1'b0;
            pipe_flush_pc_op1 = $urandom;
            pipe_flush_pc_op2 = $urandom;
        end
        if (halt_mode) pipe_halt_req = halt_val;
        else if ($urandom_range(99) < halt_pct) pipe_halt_req = ~pipe_halt_req;
        ifu_cmd_rdy = ($urandom_range(99) < cmd_rdy_pct);
        ifu_ir_rdy  = ($urandom_range(99) < ir_rdy_pct);
        if (!drive_reset && (rsp_q.size() > 0) && ($urandom_range(99) < rsp_pct)) begin
            logic [31:0] a;
            a = rsp_q.pop_front();
            ifu_rsp_vld   = 1'b1;
            ifu_rsp_rdata = rsp_word(a);
            ifu_rsp_err   = (a == err_addr) || ($urandom_range(99) < err_pct);
        end else begin
            ifu_rsp_vld   = 1'b0;
            ifu_rsp_rdata = $urandom;
            ifu_rsp_err   = $urandom_range(1) != 0;
        end

        @(negedge clk);
        tgt      = pipe_flush_pc_op1 + pipe_flush_pc_op2;
        exp_addr = m_pend ? reset_vector : m_pc;
        exp_cmd  = !pipe_flush_req && !pipe_halt_req && !m_lock &&
                   (m_ots.size() < OTS_MAX) && ((m_ots.size() + m_buf.size()) < BUF_DEPTH);
        exp_ir   = (m_buf.size() > 0) && !pipe_flush_req;

        chk("cmd_vld", 32'(ifu_cmd_vld), 32'(exp_cmd));
        if (exp_cmd) chk("cmd_addr", ifu_cmd_addr, exp_addr);
        chk("ir_vld", 32'(ifu_ir_vld), 32'(exp_ir));
        if (exp_ir) begin
            chk("ifu_pc", ifu_pc, m_buf[0].pc);
            chk("ifu_ir", ifu_ir, m_buf[0].ir);
            chk("ifu_flags", {30'd0, ifu_buserr, ifu_misalgn}, {30'd0, m_buf[0].err, m_buf[0].mis});
        end
        chk("halt_ack", 32'(pipe_halt_ack), 32'(m_hack));
        chk("tied_ctrl", 32'({pipe_flush_ack, ifu_rsp_rdy, ifu_cmd_write, ifu_cmd_size, ifu_cmd_wstrb}), 32'h320);
        chk("tied_wdata", ifu_cmd_wdata, 32'd0);

        if (!reset && ifu_cmd_vld && ifu_cmd_rdy) begin
            rsp_q.push_back(ifu_cmd_addr);
            cmd_log.push_back(ifu_cmd_addr);
        end

        if (!reset) begin
            hs = exp_cmd && ifu_cmd_rdy;
            if (exp_ir && ifu_ir_rdy) void'(m_buf.pop_front());
            if (ifu_rsp_vld && (m_ots.size() > 0)) begin
                o = m_ots.pop_front();
                if (!o.drop && !pipe_flush_req) begin
                    e.ir = ifu_rsp_rdata; e.pc = o.pc; e.err = ifu_rsp_err; e.mis = 1'b0;
                    m_buf.push_back(e);
                end
            end
            if (hs) begin
                o.pc = exp_addr; o.drop = 1'b0;
                m_ots.push_back(o);
                m_pc   = exp_addr + 32'd4;
                m_pend = 1'b0;
            end
            if (pipe_flush_req) begin
                m_buf.delete();
                for (int i = 0; i < m_ots.size(); i++) m_ots[i].drop = 1'b1;
                m_pc   = tgt;
                m_pend = 1'b0;
                m_lock = (tgt[1:0] != 2'b00);
                if (m_lock) begin
                    e.ir = 32'd0; e.pc = tgt; e.err = 1'b0; e.mis = 1'b1;
                    m_buf.push_back(e);
                end
            end
            m_hack = pipe_halt_req && (m_ots.size() == 0);
        end
    endtask

    task automatic drain();
        cmd_rdy_pct = 0; rsp_pct = 100; ir_rdy_pct = 100;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        int n0;
        logic found;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; drive_reset = 1'b1;
        reset_vector = 32'h8000_0000;
        pipe_flush_req = 1'b0; pipe_flush_pc_op1 = 32'd0; pipe_flush_pc_op2 = 32'd0;
        pipe_halt_req = 1'b0; ifu_cmd_rdy = 1'b0; ifu_rsp_vld = 1'b0;
        ifu_rsp_rdata = 32'd0; ifu_rsp_err = 1'b0; ifu_ir_rdy = 1'b0;
        halt_mode = 1'b1; halt_val = 1'b0; force_flush = 1'b0;
        f_op1 = 32'd0; f_op2 = 32'd0;
        cmd_rdy_pct = 100; ir_rdy_pct = 0; rsp_pct = 100; flush_pct = 0; halt_pct = 0; err_pct = 0;
        err_addr = 32'h8000_0004;
        model_reset();

        // Reset state
        tick();
        chk("rst_ir_vld", 32'(ifu_ir_vld), 32'd0);
        chk("rst_halt_ack", 32'(pipe_halt_ack), 32'd0);
        chk("rst_cmd_vld", 32'(ifu_cmd_vld), 32'd1);
        chk("rst_cmd_addr", ifu_cmd_addr, 32'h8000_0000);
        tick();

        // Buffer fill with EXU stalled: four reads, then stop
        drive_reset = 1'b0;
        cmd_log.delete();
        for (int i = 0; i < 8; i++) tick();
        chk("fill_cmd_count", 32'(cmd_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < cmd_log.size()) chk("fill_cmd_addr", cmd_log[k], 32'h8000_0000 + 32'(4 * k));
        chk("fill_cmd_vld", 32'(ifu_cmd_vld), 32'd0);
        chk("fill_model_buf", 32'(m_buf.size()), 32'd4);
        chk("fill_head_pc", ifu_pc, 32'h8000_0000);
        chk("fill_head_ir", ifu_ir, 32'h5EAD_0000);

        // Bus error on the second word only
        cmd_rdy_pct = 0; ir_rdy_pct = 100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("err_pc", ifu_pc, 32'h8000_0000 + 32'(4 * k));
            chk("err_buserr", 32'(ifu_buserr), (k == 1) ? 32'd1 : 32'd0);
        end

        // Flush with two reads in flight
        drain();
        cmd_rdy_pct = 100; rsp_pct = 0; ir_rdy_pct = 100;
        tick(); tick();
        chk("fl_model_ots", 32'(m_ots.size()), 32'd2);
        cmd_rdy_pct = 0;
        force_flush = 1'b1; f_op1 = 32'h100; f_op2 = 32'h20;
        tick();
        chk("fl_ir_vld_flush", 32'(ifu_ir_vld), 32'd0);
        rsp_pct = 100;
        tick(); chk("fl_drop1", 32'(ifu_ir_vld), 32'd0);
        tick(); chk("fl_drop2", 32'(ifu_ir_vld), 32'd0);
        cmd_rdy_pct = 100;
        tick();
        chk("fl_cmd_vld", 32'(ifu_cmd_vld), 32'd1);
        chk("fl_cmd_addr", ifu_cmd_addr, 32'h120);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found) begin
                tick();
                if (ifu_ir_vld) begin
                    found = 1'b1;
                    chk("fl_first_pc", ifu_pc, 32'h120);
                end
            end
        end
        chk("fl_first_seen", 32'(found), 32'd1);

        // Halt with two reads in flight
        drain();
        cmd_rdy_pct = 100; rsp_pct = 0; ir_rdy_pct = 100;
        tick(); tick();
        halt_val = 1'b1;
        tick(); chk("halt_ack_h1", 32'(pipe_halt_ack), 32'd0); chk("halt_cmd_h1", 32'(ifu_cmd_vld), 32'd0);
        tick(); chk("halt_ack_h2", 32'(pipe_halt_ack), 32'd0);
        rsp_pct = 100;
        tick(); chk("halt_ack_r1", 32'(pipe_halt_ack), 32'd0); chk("halt_cmd_r1", 32'(ifu_cmd_vld), 32'd0);
        tick(); chk("halt_ack_r2", 32'(pipe_halt_ack), 32'd0);
        tick(); chk("halt_ack_rise", 32'(pipe_halt_ack), 32'd1); chk("halt_cmd_rise", 32'(ifu_cmd_vld), 32'd0);
        halt_val = 1'b0;
        tick(); chk("halt_ack_hold", 32'(pipe_halt_ack), 32'd1);
        tick(); chk("halt_ack_fall", 32'(pipe_halt_ack), 32'd0);

        // Misaligned redirect
        drain();
        cmd_rdy_pct = 100; rsp_pct = 100; ir_rdy_pct = 0;
        force_flush = 1'b1; f_op1 = 32'h0; f_op2 = 32'h102;
        tick();
        n0 = cmd_log.size();
        tick();
        chk("mis_ir_vld", 32'(ifu_ir_vld), 32'd1);
        chk("mis_flag", 32'(ifu_misalgn), 32'd1);
        chk("mis_pc", ifu_pc, 32'h102);
        chk("mis_ir", ifu_ir, 32'd0);
        chk("mis_buserr", 32'(ifu_buserr), 32'd0);
        chk("mis_cmd_vld", 32'(ifu_cmd_vld), 32'd0);
        ir_rdy_pct = 50;
        for (int i = 0; i < 10; i++) tick();
        chk("mis_no_cmds", 32'(cmd_log.size()), 32'(n0));

        // Fetch address wrap
        cmd_rdy_pct = 100; rsp_pct = 100; ir_rdy_pct = 100;
        force_flush = 1'b1; f_op1 = 32'hFFFF_FFF0; f_op2 = 32'h0000_000C;
        n0 = cmd_log.size();
        tick(); tick(); tick();
        chk("wrap_cmd_count", 32'(cmd_log.size() >= n0 + 2), 32'd1);
        if (cmd_log.size() >= n0 + 2) begin
            chk("wrap_addr0", cmd_log[n0], 32'hFFFF_FFFC);
            chk("wrap_addr1", cmd_log[n0 + 1], 32'h0000_0000);
        end

        // Randomized phases
        halt_mode = 1'b0; pipe_halt_req = 1'b0; err_addr = 32'h1;
        cmd_rdy_pct = 70; ir_rdy_pct = 60; rsp_pct = 60; flush_pct = 3; halt_pct = 4; err_pct = 10;
        for (int i = 0; i < 1200; i++) tick();

        drive_reset = 1'b1;
        tick();
        reset_vector = $urandom & 32'hFFFF_FFFC;
        tick();
        drive_reset = 1'b0;

        cmd_rdy_pct = 95; ir_rdy_pct = 30; rsp_pct = 90; flush_pct = 2; halt_pct = 2; err_pct = 20;
        for (int i = 0; i < 1000; i++) tick();
        cmd_rdy_pct = 40; ir_rdy_pct = 90; rsp_pct = 30; flush_pct = 8; halt_pct = 6; err_pct = 5;
        for (int i = 0; i < 1000; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
